// File: rtl/mem_arbiter_if.sv
// Bundles the instruction port, data port and SRAM port of the unified-memory arbiter.
interface mem_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rd_data;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_we;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rd_data;

  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [BE_W-1:0]   m_we;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wr_data, m_rd_data,
    output i_gnt, i_rvalid, i_rd_data, d_gnt, d_rvalid, d_rd_data,
    output m_en, m_addr, m_we, m_wr_data
  );

  // Requester and SRAM side
  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wr_data, m_rd_data,
    input  i_gnt, i_rvalid, i_rd_data, d_gnt, d_rvalid, d_rd_data,
    input  m_en, m_addr, m_we, m_wr_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access; data wins
// unless the fetch has waited MAX_WAIT cycles. Read data returns one cycle after grant.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT    = 3,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               inst_prio;
  logic               i_gnt_c;
  logic               d_gnt_c;
  logic               i_rvalid_c;
  logic               d_rvalid_c;
  logic [DATA_W-1:0]  i_rd_data_c;
  logic [DATA_W-1:0]  d_rd_data_c;
  logic [DATA_W-1:0]  i_hold;
  logic [DATA_W-1:0]  d_hold;

  // Winner selection; reset masks every grant
  always_comb begin
    inst_prio = (starve_cnt == CNT_W'(MAX_WAIT));
    d_gnt_c   = !rst && bus.d_req && (!bus.i_req || !inst_prio);
    i_gnt_c   = !rst && bus.i_req && !d_gnt_c;
  end

  // Pending-response state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next pending state and response steering
  always_comb begin
    state_nxt   = IDLE;
    i_rvalid_c  = 1'b0;
    d_rvalid_c  = 1'b0;
    i_rd_data_c = i_hold;
    d_rd_data_c = d_hold;
    if (i_gnt_c)                                state_nxt = RD_I;
    else if (d_gnt_c && bus.d_we == BE_W'(0))   state_nxt = RD_D;
    if (!rst) begin
      case (state)
        RD_I: begin
          i_rvalid_c  = 1'b1;
          i_rd_data_c = bus.m_rd_data;
        end
        RD_D: begin
          d_rvalid_c  = 1'b1;
          d_rd_data_c = bus.m_rd_data;
        end
        default: ;
      endcase
    end
  end

  // Consecutive denied-fetch counter, saturating at MAX_WAIT
  always_ff @(posedge clk) begin
    if (rst)                           starve_cnt <= '0;
    else if (!bus.i_req || i_gnt_c)    starve_cnt <= '0;
    else if (!inst_prio)               starve_cnt <= starve_cnt + CNT_W'(1);
  end

  // Hold registers keep the last response for stalled requesters
  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold <= RESET_INSTR;
      d_hold <= '0;
    end else begin
      if (state == RD_I) i_hold <= bus.m_rd_data;
      if (state == RD_D) d_hold <= bus.m_rd_data;
    end
  end

  assign bus.i_gnt     = i_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.i_rvalid  = i_rvalid_c;
  assign bus.d_rvalid  = d_rvalid_c;
  assign bus.i_rd_data = i_rd_data_c;
  assign bus.d_rd_data = d_rd_data_c;

  assign bus.m_en      = i_gnt_c | d_gnt_c;
  assign bus.m_addr    = i_gnt_c ? bus.i_addr : (d_gnt_c ? bus.d_addr : ADDR_W'(0));
  assign bus.m_we      = d_gnt_c ? bus.d_we : BE_W'(0);
  assign bus.m_wr_data = bus.d_wr_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed stimulus for mem_arbiter, checked every cycle against a
// behavioural model of arbitration, SRAM contents and response steering.
module tb_mem_arbiter;
  localparam int unsigned MAX_WAIT    = 3;
  localparam logic [31:0] RESET_INSTR = 32'h0000_0013;
  localparam int unsigned WORDS       = 64;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if ifc();

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .RESET_INSTR(RESET_INSTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int k);
    if (k == 4)  return 32'hDEAD_BEEF;
    if (k == 32) return 32'hFFFF_FFFF;
    return {8'hC0, 24'(k)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM environment: one access per cycle, read data valid the next cycle
  logic [31:0] sram [WORDS];
  logic        sram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int k = 0; k < int'(WORDS); k++) sram[k] <= init_word(k);
      sram_loaded <= 1'b1;
    end else if (ifc.m_en) begin
      if (ifc.m_we == 4'b0) ifc.m_rd_data <= sram[ifc.m_addr[7:2]];
      else
        for (int b = 0; b < 4; b++)
          if (ifc.m_we[b]) sram[ifc.m_addr[7:2]][8*b +: 8] <= ifc.m_wr_data[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  bit          model_live = 1'b0;
  int          wait_cnt;
  bit          pend_i, pend_d;
  logic [31:0] pend_i_data, pend_d_data;
  logic [31:0] hold_i_data, hold_d_data;
  bit          keep_i = 1'b0, keep_d = 1'b0;

  // Compare DUT against the model mid-cycle, then advance the model past the edge
  always @(negedge clk) begin
    bit          ig, dg, prio;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    prio = (wait_cnt == int'(MAX_WAIT));
    dg   = !rst && ifc.d_req && (!ifc.i_req || !prio);
    ig   = !rst && ifc.i_req && !dg;
    e_addr = ig ? ifc.i_addr : (dg ? ifc.d_addr : 32'h0);
    e_we   = dg ? ifc.d_we : 4'b0;
    if (model_live) begin
      chk("i_gnt", 32'(ifc.i_gnt), 32'(ig));
      chk("d_gnt", 32'(ifc.d_gnt), 32'(dg));
      chk("m_en", 32'(ifc.m_en), 32'(ig | dg));
      chk("m_addr", ifc.m_addr, e_addr);
      chk("m_we", 32'(ifc.m_we), 32'(e_we));
      if (e_we != 4'b0) chk("m_wr_data", ifc.m_wr_data, ifc.d_wr_data);
      chk("i_rvalid", 32'(ifc.i_rvalid), 32'(pend_i && !rst));
      chk("d_rvalid", 32'(ifc.d_rvalid), 32'(pend_d && !rst));
      chk("i_rd_data", ifc.i_rd_data, (pend_i && !rst) ? pend_i_data : hold_i_data);
      chk("d_rd_data", ifc.d_rd_data, (pend_d && !rst) ? pend_d_data : hold_d_data);
    end
    if (rst) begin
      if (!model_live)
        for (int k = 0; k < int'(WORDS); k++) ref_mem[k] = init_word(k);
      model_live  = 1'b1;
      wait_cnt    = 0;
      pend_i      = 1'b0;
      pend_d      = 1'b0;
      hold_i_data = RESET_INSTR;
      hold_d_data = 32'h0;
      keep_i      = 1'b0;
      keep_d      = 1'b0;
    end else if (model_live) begin
      if (pend_i) hold_i_data = pend_i_data;
      if (pend_d) hold_d_data = pend_d_data;
      if (ifc.i_req && !ig) wait_cnt = (wait_cnt < int'(MAX_WAIT)) ? wait_cnt + 1 : wait_cnt;
      else                  wait_cnt = 0;
      pend_i = ig;
      pend_d = dg && (ifc.d_we == 4'b0);
      if (ig) pend_i_data = ref_mem[ifc.i_addr[7:2]];
      if (pend_d) pend_d_data = ref_mem[ifc.d_addr[7:2]];
      if (dg && ifc.d_we != 4'b0)
        for (int b = 0; b < 4; b++)
          if (ifc.d_we[b]) ref_mem[ifc.d_addr[7:2]][8*b +: 8] = ifc.d_wr_data[8*b +: 8];
      keep_i = ifc.i_req && !ig;
      keep_d = ifc.d_req && !dg;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.i_req = 1'b0; ifc.i_addr = 32'h0;
    ifc.d_req = 1'b0; ifc.d_addr = 32'h0; ifc.d_we = 4'b0; ifc.d_wr_data = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_i_gnt", 32'(ifc.i_gnt), 32'h0);
    chk("rst_m_en", 32'(ifc.m_en), 32'h0);
    chk("rst_i_rd_data", ifc.i_rd_data, 32'h0000_0013);
    chk("rst_d_rd_data", ifc.d_rd_data, 32'h0);

    // Fetch only
    next_cycle(); rst = 1'b0; ifc.i_req = 1'b1; ifc.i_addr = 32'h10;
    @(negedge clk); chk("fetch_gnt", 32'(ifc.i_gnt), 32'h1);
    next_cycle(); ifc.i_req = 1'b0;
    @(negedge clk); chk("fetch_rvalid", 32'(ifc.i_rvalid), 32'h1);
    chk("fetch_data", ifc.i_rd_data, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk); chk("fetch_hold", ifc.i_rd_data, 32'hDEAD_BEEF);

    // Collision: data wins, fetch follows
    next_cycle(); ifc.i_req = 1'b1; ifc.i_addr = 32'h10; ifc.d_req = 1'b1; ifc.d_addr = 32'h40;
    @(negedge clk); chk("coll_d_gnt", 32'(ifc.d_gnt), 32'h1);
    chk("coll_i_gnt", 32'(ifc.i_gnt), 32'h0);
    next_cycle(); ifc.d_req = 1'b0;
    @(negedge clk); chk("coll_starve", 32'(dut.starve_cnt), 32'h1);
    chk("coll_d_rvalid", 32'(ifc.d_rvalid), 32'h1);
    chk("coll_i_rvalid", 32'(ifc.i_rvalid), 32'h0);
    chk("coll_d_data", ifc.d_rd_data, 32'hC000_0010);
    next_cycle(); ifc.i_req = 1'b0;

    // Starvation under continuous data traffic
    next_cycle(); ifc.i_req = 1'b1; ifc.i_addr = 32'h20; ifc.d_req = 1'b1; ifc.d_addr = 32'h44;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("starve_i_gnt_c%0d", c), 32'(ifc.i_gnt), 32'(c == 3));
      chk($sformatf("starve_d_gnt_c%0d", c), 32'(ifc.d_gnt), 32'(c != 3));
      next_cycle();
    end
    idle_inputs();

    // Store then load back
    next_cycle(); ifc.d_req = 1'b1; ifc.d_we = 4'b0011; ifc.d_addr = 32'h80; ifc.d_wr_data = 32'h1234_ABCD;
    @(negedge clk); chk("store_m_we", 32'(ifc.m_we), 32'h3);
    next_cycle(); idle_inputs();
    @(negedge clk); chk("store_no_rvalid", 32'(ifc.d_rvalid), 32'h0);
    next_cycle(); ifc.d_req = 1'b1; ifc.d_addr = 32'h80;
    next_cycle(); ifc.d_req = 1'b0;
    @(negedge clk); chk("store_readback", ifc.d_rd_data, 32'hFFFF_ABCD);

    // Back-to-back fetch, load, fetch
    next_cycle(); ifc.i_req = 1'b1; ifc.i_addr = 32'h10;
    next_cycle(); ifc.i_req = 1'b0; ifc.d_req = 1'b1; ifc.d_addr = 32'h40;
    @(negedge clk); chk("b2b_i_data", ifc.i_rd_data, 32'hDEAD_BEEF);
    next_cycle(); ifc.d_req = 1'b0; ifc.i_req = 1'b1; ifc.i_addr = 32'h20;
    @(negedge clk); chk("b2b_d_data", ifc.d_rd_data, 32'hC000_0010);
    chk("b2b_d_rvalid", 32'(ifc.d_rvalid), 32'h1);
    next_cycle(); ifc.i_req = 1'b0;
    @(negedge clk); chk("b2b_i_data2", ifc.i_rd_data, 32'hC000_0008);

    // Reset while a fetch response is due
    next_cycle(); ifc.i_req = 1'b1; ifc.i_addr = 32'h44;
    next_cycle(); ifc.i_req = 1'b0; rst = 1'b1;
    @(negedge clk); chk("rstrd_i_rvalid", 32'(ifc.i_rvalid), 32'h0);
    next_cycle(); rst = 1'b0;
    @(negedge clk); chk("rstrd_i_data", ifc.i_rd_data, 32'h0000_0013);
    chk("rstrd_starve", 32'(dut.starve_cnt), 32'h0);

    // Randomized traffic, honouring the hold-while-stalled rule
    repeat (3000) begin
      next_cycle();
      rst = ($urandom_range(0, 199) == 0);
      if (!keep_i) begin
        ifc.i_req  = ($urandom_range(0, 3) != 0);
        ifc.i_addr = 32'($urandom_range(0, WORDS - 1)) << 2;
      end
      if (!keep_d) begin
        ifc.d_req     = ($urandom_range(0, 2) != 0);
        ifc.d_addr    = 32'($urandom_range(0, WORDS - 1)) << 2;
        ifc.d_we      = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
        ifc.d_wr_data = $urandom;
      end
    end
    next_cycle(); rst = 1'b0; idle_inputs();
    next_cycle();
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
